// File: rtl/mmio_uart_responder.sv
// mmio_uart_responder -- memory-mapped UART byte FIFOs plus optional perf counters.
//
// Register window: 32 bytes at IO_BASE. A hit requires addr[31:5] == IO_BASE[31:5].
// The word offset is addr[4:2].
//   0 status   (RO)  bit0 TX not full, bit1 RX not empty, bit2 sticky tx_overflow.
//                    A read of this register clears tx_overflow.
//   1 rx data  (RO)  {24'b0, head byte}. A read pops one entry. Reading an empty FIFO returns 0.
//   2 tx data  (WO)  Any we bit set pushes din[7:0]. A write while full is dropped and sets tx_overflow.
//   4 cycles   (RO)  Free-running cycle count.
//   5 retired  (RO)  Count of inst_retire pulses.
//   6 clear    (WO)  A write zeroes both counters.
//
// Build option: MMIO_UART_COUNTERS_EN compiles in the two counters. When it is left
// undefined, offsets 4 and 5 read 0 and writes to offset 6 do nothing.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   addr, re, we, din, dout      CPU data-side bus. dout is registered one cycle after re.
//   tx_data, tx_valid, tx_ready  byte stream to the UART transmitter
//   rx_data, rx_valid, rx_ready  byte stream from the UART receiver
//   inst_retire                  one instruction retired this cycle

// Synchronous byte FIFO. It uses one extra pointer bit to tell full from empty.
// A push into a full FIFO is ignored. A pop from an empty FIFO is ignored.
module mmio_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         push_ok, pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset. The pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module mmio_uart_responder #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        inst_retire
);
  localparam logic [2:0] OFF_STAT = 3'd0, OFF_RXD = 3'd1, OFF_TXD = 3'd2,
                         OFF_CYC  = 3'd4, OFF_RET = 3'd5, OFF_CLR = 3'd6;

  logic        hit, rd_hit, wr_hit;
  logic [2:0]  off;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push_req, tx_push, tx_pop, tx_drop;
  logic        rx_push, rx_pop;
  logic [7:0]  rx_head;
  logic        tx_ovf;
  logic [31:0] rd_val;

  assign hit    = (addr[31:5] == IO_BASE[31:5]);
  assign off    = addr[4:2];
  assign rd_hit = hit && re;
  assign wr_hit = hit && (|we);

  // TX acceptance uses the full flag from before the edge. A drain in the same cycle
  // does not rescue a write that arrives while the FIFO is full.
  assign tx_push_req = wr_hit && (off == OFF_TXD);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_drop     = tx_push_req && tx_full;
  assign tx_valid    = !tx_empty;
  assign tx_pop      = tx_valid && tx_ready;

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_hit && (off == OFF_RXD) && !rx_empty;

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk, .rst_n, .push(tx_push), .pop(tx_pop), .wdata(din[7:0]),
    .rdata(tx_data), .full(tx_full), .empty(tx_empty)
  );

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk, .rst_n, .push(rx_push), .pop(rx_pop), .wdata(rx_data),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // A status read clears tx_overflow. An overflow in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             tx_ovf <= 1'b0;
    else if (tx_drop)                       tx_ovf <= 1'b1;
    else if (rd_hit && (off == OFF_STAT))   tx_ovf <= 1'b0;
  end

`ifdef MMIO_UART_COUNTERS_EN
  logic [31:0] cyc_cnt, ret_cnt;
  logic        cnt_clr;
  assign cnt_clr = wr_hit && (off == OFF_CLR);

  // A clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = inst_retire;
`endif

  logic unused_bits;
  assign unused_bits = ^{din[31:8], addr[1:0]};

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STAT: rd_val = {29'b0, tx_ovf, !rx_empty, !tx_full};
      OFF_RXD:  rd_val = rx_empty ? 32'd0 : {24'b0, rx_head};
`ifdef MMIO_UART_COUNTERS_EN
      OFF_CYC:  rd_val = cyc_cnt;
      OFF_RET:  rd_val = ret_cnt;
`endif
      default:  rd_val = '0;
    endcase
  end

  // dout changes only on a read. A read that misses the window returns 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  dout <= '0;
    else if (re) dout <= hit ? rd_val : 32'd0;
  end
endmodule
